// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: FSM state encoding, ground-line and
// landing heights, and screen geometry used by the player block and the controller.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DEAD  = 2'b10,
      ST_PAUSE = 2'b11
   } state_t;

   localparam logic [8:0] SCREEN_H   = 9'd480;
   localparam logic [8:0] SCREEN_TOP = 9'd0;
   localparam logic [8:0] PLAYER_H   = 9'd60;

   localparam logic [8:0] LINE_Y0 = 9'd120;
   localparam logic [8:0] LINE_Y1 = 9'd240;
   localparam logic [8:0] LINE_Y2 = 9'd360;

   // Falling down the player's bottom edge meets a line; falling up its top edge does.
   localparam logic [8:0] LAND_DN_1 = LINE_Y1 - PLAYER_H;
   localparam logic [8:0] LAND_DN_2 = LINE_Y2 - PLAYER_H;
   localparam logic [8:0] LAND_UP_0 = LINE_Y0;
   localparam logic [8:0] LAND_UP_1 = LINE_Y1;

   function automatic logic is_grounded(input logic       grav_up,
                                        input logic [8:0] h,
                                        input logic [2:0] lines_in);
      logic g;
      if (grav_up) begin
         g = ((h == LAND_UP_0) && lines_in[0]) || ((h == LAND_UP_1) && lines_in[1]);
      end else begin
         g = ((h == LAND_DN_1) && lines_in[1]) || ((h == LAND_DN_2) && lines_in[2]);
      end
      return g;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Movement tick divider: counts 0..DIV-1 while enabled, holds otherwise,
// synchronous clear has priority over counting.
module tick_gen #(
   parameter int DIV = 416667
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_r;

   assign tick = en && (cnt_r == LAST);

   // Divider counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= W'(0);
      end else if (clr) begin
         cnt_r <= W'(0);
      end else if (en) begin
         cnt_r <= (cnt_r == LAST) ? W'(0) : cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/game_controller.sv
// Run controller: IDLE/RUN/DEAD(/PAUSE) sequencing, gravity flips, death and score.
// Optional pause support is compiled in with GAME_PAUSE_EN.
module game_controller
   import game_pkg::*;
#(
   parameter int TICK_DIV     = 416667,
   parameter int SCORE_DIV    = 24,
   parameter int BOTTOM_LIMIT = int'(SCREEN_H - PLAYER_H),
   parameter int TOP_LIMIT    = int'(SCREEN_TOP)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_btn,
   input  logic        flip_btn,
   input  logic        pause_btn,
   input  logic [8:0]  height,
   input  logic [2:0]  lines,
   output logic        grav_dir,
   output logic        hold,
   output logic        player_rst_n,
   output logic        dead,
   output logic [1:0]  state,
   output logic [15:0] score
);

   localparam logic [8:0] BOTTOM_H = 9'(BOTTOM_LIMIT);
   localparam logic [8:0] TOP_H    = 9'(TOP_LIMIT);
   localparam int SW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
   localparam logic [SW-1:0] SCORE_LAST = SW'(SCORE_DIV - 1);

   state_t        state_r;
   logic          grav_r;
   logic          rst_n_r;
   logic          dead_r;
   logic [15:0]   score_r;
   logic [SW-1:0] sub_r;
   logic [1:0]    mask_r;
   logic          start_cur_r, start_prev_r;
   logic          flip_cur_r, flip_prev_r;

   logic start_rise_s, flip_rise_s, start_ok_s;
   logic run_s, tick_s, grounded_s, death_s;

   // Button edge registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         start_cur_r  <= 1'b0;
         start_prev_r <= 1'b0;
         flip_cur_r   <= 1'b0;
         flip_prev_r  <= 1'b0;
      end else begin
         start_cur_r  <= start_btn;
         start_prev_r <= start_cur_r;
         flip_cur_r   <= flip_btn;
         flip_prev_r  <= flip_cur_r;
      end
   end

`ifdef GAME_PAUSE_EN
   logic pause_cur_r, pause_prev_r;
   logic pause_rise_s;

   // Pause button edge registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pause_cur_r  <= 1'b0;
         pause_prev_r <= 1'b0;
      end else begin
         pause_cur_r  <= pause_btn;
         pause_prev_r <= pause_cur_r;
      end
   end

   assign pause_rise_s = pause_cur_r & ~pause_prev_r;
   assign start_ok_s   = start_rise_s & (state_r != ST_RUN);
`else
   logic unused_pause_s;
   assign unused_pause_s = pause_btn;
   assign start_ok_s     = start_rise_s & ((state_r == ST_IDLE) | (state_r == ST_DEAD));
`endif

   assign start_rise_s = start_cur_r & ~start_prev_r;
   assign flip_rise_s  = flip_cur_r & ~flip_prev_r;
   assign run_s        = (state_r == ST_RUN);
   assign grounded_s   = is_grounded(grav_r, height, lines);
   // A fresh run ignores the height for a few cycles while the player block resets.
   assign death_s      = run_s && (mask_r == 2'd0) && ((height >= BOTTOM_H) || (height <= TOP_H));

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (run_s),
      .clr   (start_ok_s),
      .tick  (tick_s)
   );

   // Phase FSM, gravity direction, score and player reset pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         grav_r  <= 1'b0;
         rst_n_r <= 1'b0;
         dead_r  <= 1'b0;
         score_r <= 16'd0;
         sub_r   <= SW'(0);
         mask_r  <= 2'd0;
      end else begin
         rst_n_r <= 1'b1;
         mask_r  <= (mask_r != 2'd0) ? mask_r - 2'd1 : 2'd0;
         if (start_ok_s) begin
            state_r <= ST_RUN;
            grav_r  <= 1'b0;
            rst_n_r <= 1'b0;
            dead_r  <= 1'b0;
            score_r <= 16'd0;
            sub_r   <= SW'(0);
            mask_r  <= 2'd3;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
               end
               ST_RUN: begin
                  if (tick_s) begin
                     if (sub_r == SCORE_LAST) begin
                        sub_r <= SW'(0);
                        if (score_r != 16'hFFFF) begin
                           score_r <= score_r + 16'd1;
                        end else begin
                           score_r <= score_r;
                        end
                     end else begin
                        sub_r <= sub_r + SW'(1);
                     end
                  end else begin
                     sub_r <= sub_r;
                  end
                  if (death_s) begin
                     state_r <= ST_DEAD;
                     dead_r  <= 1'b1;
                  end
`ifdef GAME_PAUSE_EN
                  else if (pause_rise_s) begin
                     state_r <= ST_PAUSE;
                  end
`endif
                  else if (flip_rise_s && grounded_s) begin
                     grav_r <= ~grav_r;
                  end else begin
                     grav_r <= grav_r;
                  end
               end
               ST_DEAD: begin
                  state_r <= ST_DEAD;
               end
`ifdef GAME_PAUSE_EN
               ST_PAUSE: begin
                  state_r <= pause_rise_s ? ST_RUN : ST_PAUSE;
               end
`endif
               default: begin
                  state_r <= ST_IDLE;
                  dead_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign hold         = ~(run_s & tick_s);
   assign grav_dir     = grav_r;
   assign player_rst_n = rst_n_r;
   assign dead         = dead_r;
   assign state        = state_r;
   assign score        = score_r;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller (TICK_DIV=4, SCORE_DIV=3); pause checks
// follow GAME_PAUSE_EN.
module tb_game_controller;

   localparam int TD = 4;
   localparam int SD = 3;

   logic        clk = 1'b0;
   logic        reset, start_btn, flip_btn, pause_btn;
   logic [8:0]  height;
   logic [2:0]  lines;
   logic        grav_dir, hold, player_rst_n, dead;
   logic [1:0]  state;
   logic [15:0] score;

   int n_cmp = 0;
   int n_bad = 0;

   game_controller #(.TICK_DIV(TD), .SCORE_DIV(SD)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_btn    (start_btn),
      .flip_btn     (flip_btn),
      .pause_btn    (pause_btn),
      .height       (height),
      .lines        (lines),
      .grav_dir     (grav_dir),
      .hold         (hold),
      .player_rst_n (player_rst_n),
      .dead         (dead),
      .state        (state),
      .score        (score)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Landing rule straight from the game description.
   function automatic bit tb_grounded(input bit g, input int h, input bit [2:0] ln);
      if (g == 1'b0) return ((h == 180) && ln[1]) || ((h == 300) && ln[2]);
      else           return ((h == 120) && ln[0]) || ((h == 240) && ln[1]);
   endfunction

   function automatic int exp_score(input int k);
      int s;
      s = (k / TD) / SD;
      return (s > 65535) ? 65535 : s;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      start_btn = 1'b1;
      cyc(2);
      start_btn = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start_btn = 1'b0; flip_btn = 1'b0; pause_btn = 1'b0;
      height = 9'd200; lines = 3'b000;
      cyc(3);
      n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got %b want 00", state); end
      n_cmp++; if ({grav_dir, hold, player_rst_n, dead} !== 4'b0100) begin
         n_bad++; $display("FAIL reset_outs got grav/hold/rst_n/dead=%b want 0100", {grav_dir, hold, player_rst_n, dead}); end
      n_cmp++; if (score !== 16'd0) begin n_bad++; $display("FAIL reset_score got %0d want 0", score); end
      reset = 1'b0;
      cyc(1);
      n_cmp++; if (player_rst_n !== 1'b1) begin n_bad++; $display("FAIL idle_rst_n got %b want 1", player_rst_n); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (hold !== 1'b1) begin n_bad++; $display("FAIL idle_hold cycle %0d got %b want 1", i, hold); end
         cyc(1);
      end
   endtask

   task automatic test_start_hold();
      start_btn = 1'b1;
      cyc(1);
      n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL start_lat1 got %b want 00", state); end
      cyc(1);
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL start_state got %b want 01", state); end
      n_cmp++; if (player_rst_n !== 1'b0) begin n_bad++; $display("FAIL start_rst_pulse got %b want 0", player_rst_n); end
      n_cmp++; if (grav_dir !== 1'b0 || score !== 16'd0) begin
         n_bad++; $display("FAIL start_clear got grav=%b score=%0d want 0/0", grav_dir, score); end
      start_btn = 1'b0;
      cyc(1);
      n_cmp++; if (player_rst_n !== 1'b1) begin n_bad++; $display("FAIL start_rst_end got %b want 1", player_rst_n); end
      for (int k = 1; k < 17; k++) begin
         n_cmp++; if (hold !== ((k % TD) != TD - 1)) begin
            n_bad++; $display("FAIL run_hold k=%0d got %b want %b", k, hold, (k % TD) != TD - 1); end
         cyc(1);
      end
      n_cmp++; if (score !== 16'(exp_score(17))) begin n_bad++; $display("FAIL run_score got %0d want %0d", score, exp_score(17)); end
   endtask

   task automatic test_flip();
      height = 9'd180; lines = 3'b010; flip_btn = 1'b1;
      cyc(1);
      n_cmp++; if (grav_dir !== 1'b0) begin n_bad++; $display("FAIL flip_lat1 got %b want 0", grav_dir); end
      cyc(1);
      n_cmp++; if (grav_dir !== 1'b1) begin n_bad++; $display("FAIL flip_dn180 got %b want 1", grav_dir); end
      flip_btn = 1'b0; height = 9'd240; lines = 3'b000;
      cyc(1);
      flip_btn = 1'b1;
      cyc(2);
      n_cmp++; if (grav_dir !== 1'b1) begin n_bad++; $display("FAIL flip_airborne got %b want 1", grav_dir); end
      lines = 3'b010;
      cyc(3);
      n_cmp++; if (grav_dir !== 1'b1) begin n_bad++; $display("FAIL flip_not_queued got %b want 1", grav_dir); end
      flip_btn = 1'b0;
      cyc(1);
      flip_btn = 1'b1;
      cyc(2);
      n_cmp++; if (grav_dir !== 1'b0) begin n_bad++; $display("FAIL flip_up240 got %b want 0", grav_dir); end
      flip_btn = 1'b0; height = 9'd300; lines = 3'b100;
      cyc(1);
      flip_btn = 1'b1;
      cyc(2);
      n_cmp++; if (grav_dir !== 1'b1) begin n_bad++; $display("FAIL flip_dn300 got %b want 1", grav_dir); end
      flip_btn = 1'b0; height = 9'd200; lines = 3'b000;
      cyc(1);
   endtask

   task automatic test_death();
      height = 9'd419;
      cyc(4);
      n_cmp++; if (state !== 2'b01 || dead !== 1'b0) begin
         n_bad++; $display("FAIL alive_419 got state=%b dead=%b want 01/0", state, dead); end
      height = 9'd420;
      cyc(1);
      n_cmp++; if (state !== 2'b10 || dead !== 1'b1) begin
         n_bad++; $display("FAIL death_bottom got state=%b dead=%b want 10/1", state, dead); end
      n_cmp++; if (grav_dir !== 1'b1) begin n_bad++; $display("FAIL dead_grav_frozen got %b want 1", grav_dir); end
      height = 9'd200;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         n_cmp++; if (hold !== 1'b1) begin n_bad++; $display("FAIL dead_hold cycle %0d got %b want 1", i, hold); end
      end
      height = 9'd180; lines = 3'b010; start_btn = 1'b1; flip_btn = 1'b1;
      cyc(2);
      n_cmp++; if (state !== 2'b01 || grav_dir !== 1'b0) begin
         n_bad++; $display("FAIL start_beats_flip got state=%b grav=%b want 01/0", state, grav_dir); end
      start_btn = 1'b0; flip_btn = 1'b0;
      cyc(2);
      n_cmp++; if (grav_dir !== 1'b0) begin n_bad++; $display("FAIL flip_discarded got %b want 0", grav_dir); end
      cyc(3);
      flip_btn = 1'b1;
      cyc(2);
      n_cmp++; if (grav_dir !== 1'b1) begin n_bad++; $display("FAIL flip_after_restart got %b want 1", grav_dir); end
      flip_btn = 1'b0; height = 9'd0;
      cyc(1);
      n_cmp++; if (state !== 2'b10 || dead !== 1'b1) begin
         n_bad++; $display("FAIL death_top got state=%b dead=%b want 10/1", state, dead); end
   endtask

   task automatic test_reset_midrun();
      height = 9'd200; lines = 3'b000;
      do_start();
      cyc(6);
      height = 9'd180; lines = 3'b010; flip_btn = 1'b1;
      cyc(2);
      flip_btn = 1'b0; height = 9'd200; lines = 3'b000;
      cyc(6);
      n_cmp++; if (score !== 16'(exp_score(14)) || grav_dir !== 1'b1) begin
         n_bad++; $display("FAIL pre_reset got score=%0d grav=%b want %0d/1", score, grav_dir, exp_score(14)); end
      reset = 1'b1;
      cyc(1);
      n_cmp++; if (state !== 2'b00 || score !== 16'd0) begin
         n_bad++; $display("FAIL midrun_reset got state=%b score=%0d want 00/0", state, score); end
      n_cmp++; if ({grav_dir, hold, player_rst_n, dead} !== 4'b0100) begin
         n_bad++; $display("FAIL midrun_reset_outs got %b want 0100", {grav_dir, hold, player_rst_n, dead}); end
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic test_random();
      int m_k;
      bit m_grav, fcur, fprev, fl, rise;
      int hv;
      bit [2:0] lv;
      int hset [6] = '{120, 180, 240, 300, 200, 150};
      height = 9'd200; lines = 3'b000; flip_btn = 1'b0;
      do_start();
      m_k = 0; m_grav = 1'b0; fcur = 1'b0; fprev = 1'b0;
      for (int i = 0; i < 300; i++) begin
         n_cmp++; if (state !== 2'b01 || grav_dir !== m_grav || hold !== ((m_k % TD) != TD - 1) || score !== 16'(exp_score(m_k))) begin
            n_bad++; $display("FAIL random k=%0d got state=%b grav=%b hold=%b score=%0d want 01/%b/%b/%0d",
                              m_k, state, grav_dir, hold, score, m_grav, (m_k % TD) != TD - 1, exp_score(m_k));
         end
         hv = hset[$urandom_range(0, 5)];
         lv = 3'($urandom);
         fl = 1'($urandom_range(0, 1));
         height = 9'(hv); lines = lv; flip_btn = fl;
         rise = fcur && !fprev;
         if (rise && tb_grounded(m_grav, hv, lv)) m_grav = !m_grav;
         fprev = fcur; fcur = fl;
         m_k++;
         cyc(1);
      end
      flip_btn = 1'b0; height = 9'd200; lines = 3'b000;
   endtask

   task automatic test_saturation();
      force dut.score_r = 16'hFFFD;
      cyc(1);
      release dut.score_r;
      for (int i = 0; i < 48; i++) begin
         cyc(1);
         n_cmp++; if (score < 16'hFFFD || $isunknown(score)) begin
            n_bad++; $display("FAIL sat_no_wrap cycle %0d got %h want >= fffd", i, score); end
      end
      n_cmp++; if (score !== 16'hFFFF) begin n_bad++; $display("FAIL sat_final got %h want ffff", score); end
      height = 9'd420;
      cyc(2);
      height = 9'd200;
   endtask

   task automatic test_pause();
`ifdef GAME_PAUSE_EN
      int m_k;
      do_start();
      cyc(20);
      pause_btn = 1'b1;
      cyc(1);
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL pause_lat1 got %b want 01", state); end
      cyc(1);
      pause_btn = 1'b0;
      height = 9'd180; lines = 3'b010; flip_btn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         n_cmp++; if (state !== 2'b11 || hold !== 1'b1 || score !== 16'(exp_score(22)) || grav_dir !== 1'b0) begin
            n_bad++; $display("FAIL paused cycle %0d got state=%b hold=%b score=%0d grav=%b want 11/1/%0d/0",
                              i, state, hold, score, grav_dir, exp_score(22));
         end
         cyc(1);
      end
      flip_btn = 1'b0;
      cyc(2);
      pause_btn = 1'b1;
      cyc(2);
      pause_btn = 1'b0;
      m_k = 22;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (state !== 2'b01 || hold !== ((m_k % TD) != TD - 1) || score !== 16'(exp_score(m_k))) begin
            n_bad++; $display("FAIL resume k=%0d got state=%b hold=%b score=%0d want 01/%b/%0d",
                              m_k, state, hold, score, (m_k % TD) != TD - 1, exp_score(m_k));
         end
         m_k++;
         cyc(1);
      end
`else
      do_start();
      cyc(4);
      pause_btn = 1'b1;
      cyc(3);
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL pause_ignored got %b want 01", state); end
      pause_btn = 1'b0;
      cyc(2);
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL pause_ignored2 got %b want 01", state); end
`endif
   endtask

   initial begin
      test_reset();
      test_start_hold();
      test_flip();
      test_death();
      test_reset_midrun();
      test_random();
      test_saturation();
      test_pause();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Top-level run controller for the player movement datapath.
- Sequences game phases IDLE -> RUN -> DEAD, and gates player motion with a periodic movement tick.
- Accepts gravity-flip requests only while the player is grounded; detects off-screen death; keeps a survival score.
- Drives the player block's gravity direction, freeze/hold input and active-low player reset.

Parameters:
- TICK_DIV, 416667, clk cycles per movement tick (100 MHz / 240 Hz); minimum 2.
- SCORE_DIV, 24, movement ticks per score increment; minimum 1.
- BOTTOM_LIMIT, 420, player top-left height at or above which the player is dead (fell off bottom).
- TOP_LIMIT, 0, player height at or below which the player is dead (fell off top).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start_btn  input  1  synchronized, debounced level; rising edge starts or restarts a run
- flip_btn  input  1  synchronized, debounced level; rising edge requests a gravity flip
- pause_btn  input  1  synchronized level; used only with PAUSE_EN
- height  input  9  current player top-left height from the player block
- lines  input  3  ground presence at the player x position: [0] line at 120, [1] line at 240, [2] line at 360
- grav_dir  output  1  0 = down, 1 = up; drives the player block
- hold  output  1  1 = freeze player this cycle; drives the player block's freeze input
- player_rst_n  output  1  active-low one-cycle player reset
- dead  output  1  high in DEAD state
- state  output  2  00 IDLE, 01 RUN, 10 DEAD, 11 PAUSE
- score  output  16  survival score, saturating

Behaviour:
- Reset: state = IDLE, grav_dir = 0, hold = 1, player_rst_n = 0, dead = 0, score = 0, tick counter = 0, edge registers = 0.
- Edge detect: a one-cycle rise is registered as previous-level = 0 and current-level = 1, per button.
- player_rst_n:
  - Low for exactly one cycle in the cycle after a start is accepted.
  - Otherwise high, except during reset.
- Grounded (combinational):
  - grav_dir = 0: (height == 180 and lines[1]) or (height == 300 and lines[2]).
  - grav_dir = 1: (height == 120 and lines[0]) or (height == 240 and lines[1]).
- Tick counter:
  - Counts 0 .. TICK_DIV-1, only in RUN; holds its value in all other states.
  - tick = 1 for one cycle when the counter equals TICK_DIV-1; the counter then wraps to 0.
  - Cleared to 0 on entry to RUN.
- hold = ~(state == RUN and tick). The player therefore moves exactly 1 px per tick.
- IDLE:
  - hold = 1.
  - start rise -> RUN; grav_dir is cleared to 0, score is cleared, player reset pulse is issued.
- RUN:
  - flip rise and grounded -> grav_dir toggles at the next edge.
  - flip rise when not grounded is dropped, not queued.
  - death = (height >= BOTTOM_LIMIT) or (height <= TOP_LIMIT), evaluated every cycle. When true -> DEAD at the next edge; a flip in the same cycle is ignored.
  - The death check is masked for the 2 cycles after player_rst_n, so a stale height cannot kill the player.
- DEAD:
  - hold = 1, dead = 1; score and grav_dir are frozen.
  - start rise -> RUN with the same actions as from IDLE.
- Score:
  - A tick-within-score counter advances on each tick in RUN.
  - At SCORE_DIV ticks, score increments and the counter clears.
  - Score saturates at 16'hFFFF.
- Simultaneous events:
  - start and flip in the same cycle: start wins, flip is discarded.
  - Reset has priority over everything; reset mid-run returns to IDLE with reset values.
- Latency:
  - Button rise to state or grav_dir change: 2 cycles (1 cycle edge register, 1 cycle state register).
  - Death condition to dead = 1: 1 cycle.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - pause_btn rise in RUN -> PAUSE: hold = 1; tick counter, score and grav_dir are frozen.
  - pause_btn rise in PAUSE -> RUN, resuming the tick count where it stopped.
  - start rise in PAUSE -> restart, same actions as from IDLE.
  - flip is ignored in PAUSE.
- Undefined:
  - pause_btn is unused and PAUSE (11) is unreachable.
  - An illegal state encoding recovers to IDLE.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DEAD, ST_PAUSE;
  - line heights 120/240/360 and landing heights 180/300/120/240;
  - screen constants, so the player block and this controller share one source.
- One sub-module: tick_gen.
  - Parameterised divider with enable and synchronous clear; outputs the one-cycle tick.
- The FSM, grounded logic, edge detects and score stay in game_controller.

Test Plan:
- Reset, then start rise -> state goes 00 -> 01 in 2 cycles, player_rst_n low for 1 cycle, grav_dir = 0, score = 0.
- TICK_DIV = 4, RUN -> hold low exactly 1 cycle in every 4; held high continuously in IDLE and DEAD.
- height = 180, lines = 3'b010, grav_dir = 0, flip rise -> grav_dir = 1 two cycles later. Repeat with lines = 3'b000 -> grav_dir unchanged; a later grounded cycle without a new edge -> still unchanged.
- height driven to 420 in RUN -> dead = 1 and state = 10 next cycle. height = 0 with grav_dir = 1 -> same. height = 419 -> stays RUN.
- Start and flip rising in the same cycle from DEAD -> RUN, grav_dir = 0. Reset asserted mid-RUN -> IDLE with all reset values on the next edge.
- SCORE_DIV = 1, TICK_DIV = 2, score preloaded near 16'hFFFF -> score saturates at 16'hFFFF. With GAME_PAUSE_EN, pause rise -> score and the tick counter are frozen until a second pause rise.
